// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream reader.
//   state_t            : scan FSM encoding (IDLE, FETCH, HOLD, DONE)
//   DEFAULT_ADDR_WIDTH : default ROM address width
//   DEFAULT_DATA_WIDTH : default ROM word width
//   DEPTH              : number of ROM words at the default address width
package rom_stream_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEPTH = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lookup_rom.sv
// 4-entry combinational lookup ROM that the stream reader scans.
//   addr : word address
//   dout : word stored at addr (combinational)
module lookup_rom (
  input  logic [1:0] addr,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'b0000;
    case (addr)
      2'd0: dout = 4'b0100;
      2'd1: dout = 4'b1100;
      2'd2: dout = 4'b0110;
      2'd3: dout = 4'b0111;
      default: dout = 4'b0000;
    endcase
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Address sequencer in front of a combinational ROM. Drives rom_addr, captures
// rom_data into out_data and streams the words downstream, one word per two
// cycles at most, in single-pass or continuous-loop mode.
//
// Handshake: out_data is transferred on any rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data and rom_addr stay
// stable until that transfer (or abort/reset); out_valid never drops without
// a transfer except on abort or reset.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a scan (sampled in IDLE only)
//   loop_en      : repeat the scan until abort (sampled with start)
//   start_addr   : first address (sampled with start)
//   count        : words per pass, 0 = full depth (sampled with start)
//   abort        : stop the scan, return to IDLE (ignored in IDLE)
//   rom_addr     : registered ROM address
//   rom_data     : combinational ROM word for rom_addr
//   out_data     : registered word presented downstream
//   out_valid    : out_data valid
//   out_ready    : consumer accepts out_data
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse at the end of a non-loop scan
//   dbg_state    : current FSM state
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   beats_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic                  loop_q;
  logic                  handshake;
  logic                  last_beat;
  logic                  aborting;

  assign handshake = (state == HOLD) && out_valid && out_ready;
  assign last_beat = (remaining == (ADDR_WIDTH+1)'(1));
  assign aborting  = abort && (state != IDLE);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: state_next = HOLD;
      HOLD: begin
        if (handshake) begin
          state_next = (last_beat && !loop_q) ? DONE : FETCH;
        end
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous handshake.
    if (aborting) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rom_addr     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      remaining    <= '0;
      beats_q      <= '0;
      start_addr_q <= '0;
      loop_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (aborting) begin
        // rom_addr and out_data deliberately keep their last values.
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rom_addr     <= start_addr;
              start_addr_q <= start_addr;
              loop_q       <= loop_en;
              beats_q      <= (count == '0) ? FULL_COUNT : count;
              remaining    <= (count == '0) ? FULL_COUNT : count;
            end
          end
          FETCH: begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
          end
          HOLD: begin
            if (handshake) begin
              out_valid <= 1'b0;
              remaining <= remaining - (ADDR_WIDTH+1)'(1);
              if (!last_beat) begin
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
              end else if (loop_q) begin
                rom_addr  <= start_addr_q;
                remaining <= beats_q;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader driving the lookup ROM.
module tb_rom_stream_reader;
  import rom_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] start_addr = '0;
  logic [2:0] count = '0;
  logic       abort = 1'b0;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  logic [3:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int hs_count = 0;
  int last_hs_cycle = 0;
  int done_count = 0;
  int done_cycle = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  rom_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en),
    .start_addr(start_addr), .count(count), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  lookup_rom rom (.addr(rom_addr), .dout(rom_data));

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      last_hs_cycle = cycle;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_word: got %b, no word expected", out_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL stream_word: got %b, expected %b", out_data, e);
        end
      end
    end
    if (rst_n && done) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_scan(input logic [1:0] a, input logic [2:0] c, input logic lp);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; count = c; loop_en = lp;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 2'd0; count = 3'd0; loop_en = 1'b0;
  endtask

  // Waits for the done pulse; checks its timing and that it lasts one cycle.
  task automatic wait_done(input string name);
    int base;
    bit seen;
    base = done_count;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_count != base) seen = 1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_done_after_last_hs"}, done_cycle, last_hs_cycle + 1);
      @(negedge clk); #1;
      check({name, "_done_one_cycle"}, int'(done), 0);
      check({name, "_busy_low_after"}, int'(busy), 0);
      check({name, "_done_count"}, done_count - base, 1);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1;
    end
    check({name, "_valid_seen"}, int'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int dbase;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full single pass
    out_ready = 1'b1;
    base = hs_count;
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0110); exp_q.push_back(4'b0111);
    start_scan(2'd0, 3'd0, 1'b0);
    check("full_busy", int'(busy), 1);
    wait_done("full");
    check("full_handshakes", hs_count - base, 4);
    check("full_queue_empty", exp_q.size(), 0);

    // Wrap-around 3 -> 0
    base = hs_count;
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0100);
    start_scan(2'd3, 3'd2, 1'b0);
    wait_done("wrap");
    check("wrap_handshakes", hs_count - base, 2);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Backpressure at address 1
    out_ready = 1'b0;
    base = hs_count;
    exp_q.push_back(4'b1100); exp_q.push_back(4'b0110);
    start_scan(2'd1, 3'd2, 1'b0);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 4'b1100);
      check("stall_addr", int'(rom_addr), 1);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("stall");
    check("stall_handshakes", hs_count - base, 2);
    check("stall_queue_empty", exp_q.size(), 0);

    // Loop mode with abort
    dbase = done_count;
    base = hs_count;
    exp_q.push_back(4'b0110); exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0110); exp_q.push_back(4'b0111);
    start_scan(2'd2, 3'd2, 1'b1);
    for (int i = 0; i < 40 && (hs_count - base) < 4; i++) begin
      @(posedge clk); #1;
    end
    // Fourth handshake just reloaded the pass; stall the next word, then abort.
    out_ready = 1'b0;
    check("loop_handshakes", hs_count - base, 4);
    wait_valid("loop");
    check("loop_hold_data", int'(out_data), 4'b0110);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rom_addr_held", int'(rom_addr), 2);
    check("abort_out_data_held", int'(out_data), 4'b0110);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_count - dbase, 0);
    check("loop_queue_empty", exp_q.size(), 0);

    // Start ignored while busy
    out_ready = 1'b1;
    base = hs_count;
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0110); exp_q.push_back(4'b0111);
    start_scan(2'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 2'd1; count = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 2'd0; count = 3'd0;
    wait_done("busy_start");
    check("busy_start_handshakes", hs_count - base, 4);
    check("busy_start_queue_empty", exp_q.size(), 0);

    // Reset mid-scan
    out_ready = 1'b0;
    start_scan(2'd1, 3'd3, 1'b0);
    wait_valid("midreset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rom_addr", int'(rom_addr), 0);
    check("midreset_out_data", int'(out_data), 0);
    check("midreset_done", int'(done), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
